sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 138 +++++++++++++
 tb/tb_sram_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Cache-side controller for a 16-bit asynchronous SRAM: 64-bit line reads as four
// halfword accesses, 32-bit word writes as two, each access ACCESS_CYCLES long.
module sram_ctrl #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] rdata_o,
  output logic        ready_o,
  output logic [17:0] sram_addr_o,
  output logic [15:0] sram_dq_out_o,
  input  logic [15:0] sram_dq_in_i,
  output logic        sram_dq_oe_o,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic        sram_ub_n_o,
  output logic        sram_lb_n_o
);

  localparam logic [3:0] LastCycle = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cyc_q, cyc_d;
  logic [1:0]  idx_q, idx_d;
  logic [17:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        last_cyc;

  assign last_cyc = (cyc_q == LastCycle);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        cyc_d = '0;
        idx_d = '0;
        // addr_q doubles as the latched request address for the whole transfer
        if (read_i) begin
          state_d = StRd;
          addr_d  = {adr_i[18:3], 2'b00};
          wdata_d = wdata_i;
        end else if (write_i) begin
          state_d = StWr;
          addr_d  = {adr_i[18:2], 1'b0};
          wdata_d = wdata_i;
        end
      end
      StRd: begin
        if (last_cyc) begin
          rdata_d[{idx_q, 4'b0000} +: 16] = sram_dq_in_i;
          cyc_d = '0;
          if (idx_q == 2'd3) begin
            state_d = StDone;
          end else begin
            idx_d  = idx_q + 2'd1;
            addr_d = addr_q + 18'd1;
          end
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      StWr: begin
        if (last_cyc) begin
          cyc_d = '0;
          if (idx_q == 2'd1) begin
            state_d = StDone;
          end else begin
            idx_d  = idx_q + 2'd1;
            addr_d = addr_q + 18'd1;
          end
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        cyc_d   = '0;
        idx_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  logic in_rd, in_wr;
  assign in_rd = (state_q == StRd);
  assign in_wr = (state_q == StWr);

  // Strobes decode straight from registered state, so reset forces them high at once.
  always_comb begin
    sram_dq_out_o = '0;
    if (in_wr) begin
      sram_dq_out_o = idx_q[0] ? wdata_q[31:16] : wdata_q[15:0];
    end
  end

  assign sram_addr_o  = addr_q;
  assign sram_dq_oe_o = in_wr;
  assign sram_ce_n_o  = ~(in_rd | in_wr);
  assign sram_ub_n_o  = ~(in_rd | in_wr);
  assign sram_lb_n_o  = ~(in_rd | in_wr);
  assign sram_oe_n_o  = ~in_rd;
  // Last cycle of each write access releases WE# for address/data hold.
  assign sram_we_n_o  = ~(in_wr & ~last_cyc);
  assign rdata_o      = rdata_q;
  assign ready_o      = ((state_q == StIdle) & ~read_i & ~write_i) | (state_q == StDone);

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: vector table through a scoreboard queue, an SRAM
// model on the split bus, plus a reset-abort sequence.
module tb_sram_ctrl;
  localparam int AC = 2;

  logic        clk, rst, read, write;
  logic [31:0] adr, wdata;
  logic [63:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] dq_out, dq_in;
  logic        dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

  sram_ctrl #(.ACCESS_CYCLES(AC)) dut (
    .clk           (clk),
    .rst           (rst),
    .read_i        (read),
    .write_i       (write),
    .adr_i         (adr),
    .wdata_i       (wdata),
    .rdata_o       (rdata),
    .ready_o       (ready),
    .sram_addr_o   (sram_addr),
    .sram_dq_out_o (dq_out),
    .sram_dq_in_i  (dq_in),
    .sram_dq_oe_o  (dq_oe),
    .sram_ce_n_o   (ce_n),
    .sram_oe_n_o   (oe_n),
    .sram_we_n_o   (we_n),
    .sram_ub_n_o   (ub_n),
    .sram_lb_n_o   (lb_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [17:0] PA [8] = '{18'h204, 18'h205, 18'h206, 18'h207,
                                     18'h008, 18'h009, 18'h3FFFC, 18'h3FFFD};
  localparam logic [15:0] PD [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                                     16'h8888, 16'h9999, 16'hABCD, 16'h1234};

  // SRAM model; preloaded on the first edge, which falls inside reset.
  bit [15:0] mem [0:262143];
  bit        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 8; i++) mem[PA[i]] <= PD[i];
      loaded <= 1'b1;
    end else if (!ce_n && !we_n && dq_oe) begin
      mem[sram_addr] <= dq_out;
    end
  end
  assign dq_in = oe_n ? 16'h0000 : mem[sram_addr];

  // Reference image of what the SRAM should contain.
  bit [15:0] ref_mem [0:262143];

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] adr;
    logic [31:0] wdata;
    bit          early;
    logic [31:0] adr2;
  } vec_t;

  typedef struct {
    bit          is_rd;
    logic [17:0] base;
    logic [31:0] wdata;
    logic [63:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] last_rdata = '0;

  task automatic run_vec(input int id, input vec_t v);
    exp_t e;
    int   n, seq_err;
    bit   got;
    logic [17:0] ea;
    logic [15:0] ed;
    e.is_rd = v.rd;
    e.base  = v.rd ? {v.adr[18:3], 2'b00} : {v.adr[18:2], 1'b0};
    e.wdata = v.wdata;
    if (v.rd) begin
      e.rdata = {ref_mem[e.base + 18'd3], ref_mem[e.base + 18'd2],
                 ref_mem[e.base + 18'd1], ref_mem[e.base]};
      last_rdata = e.rdata;
    end else begin
      e.rdata = last_rdata;
      ref_mem[e.base]         = v.wdata[15:0];
      ref_mem[e.base + 18'd1] = v.wdata[31:16];
    end
    e.lat = v.rd ? 4 * AC + 1 : 2 * AC + 1;
    sb.push_back(e);

    @(negedge clk);
    read = v.rd; write = v.wr; adr = v.adr; wdata = v.wdata;
    #1 check($sformatf("v%0d ready_low_on_req", id), 64'(ready), 64'd0);
    @(posedge clk);
    n = 0; got = 1'b0; seq_err = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (ready) begin
        got = 1'b1;
      end else begin
        ea = e.base + 18'((n - 1) / AC);
        if (sram_addr !== ea) seq_err++;
        if (ce_n !== 1'b0 || ub_n !== 1'b0 || lb_n !== 1'b0) seq_err++;
        if (e.is_rd) begin
          if (oe_n !== 1'b0 || we_n !== 1'b1 || dq_oe !== 1'b0) seq_err++;
        end else begin
          ed = (((n - 1) / AC) == 1) ? e.wdata[31:16] : e.wdata[15:0];
          if (oe_n !== 1'b1 || dq_oe !== 1'b1) seq_err++;
          if (we_n !== 1'(((n - 1) % AC) == AC - 1)) seq_err++;
          if (dq_out !== ed) seq_err++;
        end
        if (v.early && n == 1) begin
          read = 1'b0; write = 1'b0; adr = v.adr2; wdata = ~v.wdata;
        end
      end
    end
    read = 1'b0; write = 1'b0;
    e = sb.pop_front();
    check($sformatf("v%0d latency", id), 64'(n), 64'(e.lat));
    check($sformatf("v%0d rdata", id), rdata, e.rdata);
    check($sformatf("v%0d bus_sequence_errs", id), 64'(seq_err), 64'd0);
    check($sformatf("v%0d done_strobes", id), {ce_n, oe_n, we_n, dq_oe}, 4'b1110);
    check($sformatf("v%0d done_addr_hold", id), 64'(sram_addr),
          64'(e.base + (e.is_rd ? 18'd3 : 18'd1)));
    if (!e.is_rd) begin
      check($sformatf("v%0d mem_lo", id), 64'(mem[e.base]), 64'(e.wdata[15:0]));
      check($sformatf("v%0d mem_hi", id), 64'(mem[e.base + 18'd1]), 64'(e.wdata[31:16]));
    end
    @(negedge clk);
    check($sformatf("v%0d idle_after", id), {ready, ce_n, dq_oe}, 3'b110);
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) ref_mem[PA[i]] = PD[i];
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0408, 32'h0,         1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,         1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0408, 32'h1234_5678, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0408, 32'h5555_AAAA, 1'b1, 32'h0007_FFF8};
    vecs[5] = '{1'b0, 1'b1, 32'hFFF7_FFFE, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'hFFF7_FFF8, 32'h0,         1'b0, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0002, 32'h0000_FFFF, 1'b1, 32'h0000_0100};

    rst = 1'b1; read = 1'b0; write = 1'b0; adr = '0; wdata = '0;
    #3;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_strobes", {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe}, 6'b111110);
    check("reset_addr", 64'(sram_addr), 64'd0);
    check("reset_dq_out", 64'(dq_out), 64'd0);
    check("reset_rdata", rdata, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_req", {ready, ce_n, dq_oe}, 3'b110);

    check("v0_expected_line", 64'h4444_3333_2222_1111,
          {ref_mem[18'h207], ref_mem[18'h206], ref_mem[18'h205], ref_mem[18'h204]});
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset during the third halfword of a read aborts it with no ready pulse.
    @(negedge clk);
    read = 1'b1; adr = 32'h0000_0408;
    @(posedge clk);
    repeat (5) @(negedge clk);
    check("abort_at_3rd_halfword", 64'(sram_addr), 64'h206);
    rst = 1'b1;
    #1;
    check("abort_strobes", {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe}, 6'b111110);
    check("abort_rdata", rdata, 64'd0);
    check("abort_addr", 64'(sram_addr), 64'd0);
    check("abort_ready_with_req", 64'(ready), 64'd0);
    read = 1'b0;
    #1 check("rst_idle_ready", 64'(ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_abort_idle%0d", i), {ready, ce_n, dq_oe}, 3'b110);
    end
    run_vec(8, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
